sudoku_board_ctrl: RTL and testbench

SUDOKU_BOARD_CTRL -- requirements
Module: sudoku_board_ctrl

---
 rtl/sudoku_board_ctrl.sv | 129 ++++++++++++
 tb/tb_sudoku_board_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_board_ctrl.sv
// 9x9 board store with two arbitrated writers (usr over rec), a filled-cell
// counter and a one-cycle CHECK that samples the external validity checker.
module sudoku_board_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         rec_req,
  input  logic [6:0]   rec_pos,
  input  logic [3:0]   rec_data,
  output logic         rec_ack,
  input  logic         usr_req,
  input  logic [6:0]   usr_pos,
  input  logic [3:0]   usr_data,
  output logic         usr_ack,
  input  logic         board_ok,
  output logic [323:0] board,
  output logic [6:0]   filled_cnt,
  output logic         err,
  output logic         valid,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_e;

  state_e         state_q, state_d;
  logic [323:0]   board_q, board_d;
  logic [6:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  logic           grant;
  logic [6:0]     wr_pos;
  logic [3:0]     wr_data;
  logic [3:0]     old_digit;
  logic           bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      board_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Grants are combinational; start and reset suppress them so nothing lands.
  always_comb begin
    rec_ack = 1'b0;
    usr_ack = 1'b0;
    if (!reset && !start) begin
      case (state_q)
        LOAD: begin
          usr_ack = usr_req;
          rec_ack = rec_req & ~usr_req;
        end
        DONE:    usr_ack = usr_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    grant   = usr_ack | rec_ack;
    wr_pos  = usr_ack ? usr_pos  : rec_pos;
    wr_data = usr_ack ? usr_data : rec_data;
    bad     = (wr_pos > 7'd80) || (wr_data > 4'd9);
    old_digit = '0;
    for (int unsigned i = 0; i < 81; i++) begin
      if (wr_pos == 7'(i)) old_digit = board_q[323 - 4*i -: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    valid_d = valid_q;
    done_d  = done_q;
    if (start) begin
      state_d = LOAD;
      board_d = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD, DONE: begin
          if (grant) begin
            err_d = bad;
            if (!bad) begin
              for (int unsigned i = 0; i < 81; i++) begin
                if (wr_pos == 7'(i)) board_d[323 - 4*i -: 4] = wr_data;
              end
              if (old_digit == 4'd0 && wr_data != 4'd0)      cnt_d = cnt_q + 7'd1;
              else if (old_digit != 4'd0 && wr_data == 4'd0) cnt_d = cnt_q - 7'd1;
            end
            valid_d = 1'b0;
            done_d  = 1'b0;
            state_d = (cnt_d == 7'd81) ? CHECK : LOAD;
          end
        end
        CHECK: begin
          valid_d = board_ok;
          done_d  = 1'b1;
          state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  assign board      = board_q;
  assign filled_cnt = cnt_q;
  assign err        = err_q;
  assign valid      = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sudoku_board_ctrl.sv
// Directed bench for sudoku_board_ctrl; a behavioural sudoku checker drives board_ok.
module tb_sudoku_board_ctrl;

  logic         clk = 1'b0;
  logic         reset, start;
  logic         rec_req, usr_req;
  logic [6:0]   rec_pos, usr_pos;
  logic [3:0]   rec_data, usr_data;
  logic         rec_ack, usr_ack;
  logic         board_ok;
  logic [323:0] board;
  logic [6:0]   filled_cnt;
  logic         err, valid, done;

  int n_vec = 0;
  int n_err = 0;
  int exp_cell[81];

  always #5 clk = ~clk;

  sudoku_board_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .rec_req(rec_req), .rec_pos(rec_pos), .rec_data(rec_data), .rec_ack(rec_ack),
    .usr_req(usr_req), .usr_pos(usr_pos), .usr_data(usr_data), .usr_ack(usr_ack),
    .board_ok(board_ok), .board(board), .filled_cnt(filled_cnt),
    .err(err), .valid(valid), .done(done)
  );

  function automatic logic sudoku_ok(input logic [323:0] b);
    for (int g = 0; g < 27; g++) begin
      logic [9:0] seen;
      seen = '0;
      for (int k = 0; k < 9; k++) begin
        int r, c, d;
        if (g < 9)       begin r = g;                 c = k; end
        else if (g < 18) begin r = k;                 c = g - 9; end
        else             begin r = ((g-18)/3)*3 + k/3; c = ((g-18)%3)*3 + k%3; end
        d = int'(b[323 - 4*(r*9+c) -: 4]);
        if (d == 0 || d > 9) return 1'b0;
        if (seen[d]) return 1'b0;
        seen[d] = 1'b1;
      end
    end
    return 1'b1;
  endfunction

  always_comb board_ok = sudoku_ok(board);

  // Solved grid whose first row is 5 6 7 8 9 1 2 3 4.
  function automatic int grid(input int n);
    int r, c;
    r = n / 9;
    c = n % 9;
    return ((r*3 + r/3 + c + 4) % 9) + 1;
  endfunction

  function automatic logic [323:0] exp_board();
    logic [323:0] v;
    v = '0;
    for (int i = 0; i < 81; i++) v[323 - 4*i -: 4] = 4'(exp_cell[i]);
    return v;
  endfunction

  function automatic int exp_cnt();
    int n;
    n = 0;
    for (int i = 0; i < 81; i++) if (exp_cell[i] != 0) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [323:0] got, input logic [323:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 81; i++) exp_cell[i] = 0;
  endtask

  task automatic wr(input bit u, input int pos, input int d);
    if (u) begin usr_req = 1'b1; usr_pos = 7'(pos); usr_data = 4'(d); end
    else   begin rec_req = 1'b1; rec_pos = 7'(pos); rec_data = 4'(d); end
    #1;
    chk(u ? "usr_ack" : "rec_ack", u ? usr_ack : rec_ack, 1);
    if (pos <= 80 && d <= 9) exp_cell[pos] = d;
    cyc();
    usr_req = 1'b0;
    rec_req = 1'b0;
    chk("err", err, (pos > 80 || d > 9));
    chk("cnt", filled_cnt, exp_cnt());
    chk("board", board, exp_board());
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    clear_model();
    chk("start_board", board, '0);
    chk("start_cnt", filled_cnt, 0);
    chk("start_done", done, 0);
    chk("start_valid", valid, 0);
  endtask

  task automatic fill(input int upto, input int cell1);
    for (int i = 0; i < upto; i++)
      wr(1'b0, i, (i == 1 && cell1 >= 0) ? cell1 : grid(i));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    rec_req = 1'b0; rec_pos = '0; rec_data = '0;
    usr_req = 1'b0; usr_pos = '0; usr_data = '0;
    clear_model();
    cyc(); cyc();
    usr_req = 1'b1; rec_req = 1'b1; #1;
    chk("rst_usr_ack", usr_ack, 0);
    chk("rst_rec_ack", rec_ack, 0);
    chk("rst_board", board, '0);
    chk("rst_cnt", filled_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    cyc();
    chk("idle_usr_ack", usr_ack, 0);
    chk("idle_rec_ack", rec_ack, 0);
    usr_req = 1'b0; rec_req = 1'b0;
    cyc();
    chk("idle_board", board, '0);

    // V1: full valid grid
    do_start();
    fill(81, -1);
    chk("v1_cnt81", filled_cnt, 81);
    rec_req = 1'b1; rec_pos = 7'd0; rec_data = 4'd1; #1;
    chk("v1_check_rec_ack", rec_ack, 0);
    chk("v1_check_done", done, 0);
    rec_req = 1'b0;
    cyc();
    chk("v1_done", done, 1);
    chk("v1_valid", valid, 1);
    chk("v1_board", board, exp_board());
    rec_req = 1'b1; #1;
    chk("v1_done_rec_ack", rec_ack, 0);
    rec_req = 1'b0;
    cyc();
    chk("v1_hold_done", done, 1);
    chk("v1_hold_valid", valid, 1);

    // V2: duplicate 5 in row 0, then user correction, then identical rewrite
    do_start();
    fill(81, 5);
    cyc();
    chk("v2_done", done, 1);
    chk("v2_valid", valid, 0);
    wr(1'b1, 1, 6);
    chk("v2_fix_done", done, 0);
    chk("v2_fix_valid", valid, 0);
    cyc();
    chk("v2_recheck_done", done, 1);
    chk("v2_recheck_valid", valid, 1);
    wr(1'b1, 1, 6);
    chk("v2_same_cnt", filled_cnt, 81);
    chk("v2_same_done", done, 0);
    cyc();
    chk("v2_same_done2", done, 1);
    chk("v2_same_valid2", valid, 1);

    // V3: simultaneous requests
    do_start();
    rec_req = 1'b1; rec_pos = 7'd3; rec_data = 4'd4;
    usr_req = 1'b1; usr_pos = 7'd3; usr_data = 4'd7; #1;
    chk("v3_usr_ack", usr_ack, 1);
    chk("v3_rec_ack", rec_ack, 0);
    cyc();
    usr_req = 1'b0;
    exp_cell[3] = 7;
    chk("v3_cell7", board, exp_board());
    #1;
    chk("v3_rec_ack2", rec_ack, 1);
    cyc();
    rec_req = 1'b0;
    exp_cell[3] = 4;
    chk("v3_cell4", board, exp_board());
    chk("v3_cnt", filled_cnt, 1);

    // V4: out-of-range writes
    wr(1'b1, 81, 2);
    wr(1'b1, 0, 12);
    cyc();
    chk("v4_err_clear", err, 0);
    chk("v4_cnt", filled_cnt, 1);

    // V5: counter up/down/hold
    do_start();
    wr(1'b1, 10, 6);
    chk("v5_cnt1", filled_cnt, 1);
    wr(1'b1, 10, 0);
    chk("v5_cnt0", filled_cnt, 0);
    wr(1'b1, 10, 0);
    chk("v5_cnt0b", filled_cnt, 0);

    // V6: start abort at 40 cells, then reset during CHECK
    do_start();
    fill(40, -1);
    start = 1'b1; rec_req = 1'b1; rec_pos = 7'd40; rec_data = 4'(grid(40)); #1;
    chk("v6_abort_rec_ack", rec_ack, 0);
    cyc();
    start = 1'b0; rec_req = 1'b0;
    clear_model();
    chk("v6_abort_board", board, '0);
    chk("v6_abort_cnt", filled_cnt, 0);
    fill(81, -1);
    reset = 1'b1; usr_req = 1'b1; usr_pos = 7'd0; usr_data = 4'd5; #1;
    chk("v6_rst_usr_ack", usr_ack, 0);
    cyc();
    reset = 1'b0; usr_req = 1'b0;
    chk("v6_rst_done", done, 0);
    chk("v6_rst_valid", valid, 0);
    chk("v6_rst_cnt", filled_cnt, 0);
    chk("v6_rst_board", board, '0);
    rec_req = 1'b1; #1;
    chk("v6_idle_rec_ack", rec_ack, 0);
    cyc();
    rec_req = 1'b0;
    chk("v6_idle_done", done, 0);
    chk("v6_idle_board", board, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
